spi_tx_feeder: RTL and testbench

Transmit-side byte feeder for the SPI slave link. Accepts 16-bit compressive-sensing measurement words from the measurement pipeline and buffers them in a small FIFO. Serialises each word MSB-byte first onto the byte bus of the SPI slave transmitter, advancing on that transmitter's one-cycle `byteSent` pulse. Also drives the transmitter's `signalReceived` enable.

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_tx_feeder_if.sv | 36 +++
 rtl/sync_fifo.sv | 65 ++++++
 rtl/spi_tx_feeder.sv | 119 +++++++++++
 tb/tb_spi_tx_feeder.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// ---------------------------------------------------------------------------
// spi_pkg
// Shared types and constants for the SPI transmit-side byte feeder.
//   feeder_state_t : byte state machine states (IDLE / HI / LO)
//   SPI_FILL_BYTE  : byte presented when no data is available (idle-high MISO)
//   SPI_WORD_W     : measurement word width
//   SPI_BYTE_W     : SPI byte width
// ---------------------------------------------------------------------------
package spi_pkg;

  localparam int SPI_WORD_W = 16;
  localparam int SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_BYTE = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/spi_tx_feeder_if.sv
// ---------------------------------------------------------------------------
// spi_tx_feeder_if
// Bundles the measurement-side push handshake and the SPI-transmitter-side
// byte bus of the feeder.
//   in_data/in_valid/in_ready : word push handshake (producer -> feeder)
//   data/byteSent             : byte bus and consume pulse (feeder <-> SPI tx)
//   signalReceived            : transmitter enable
//   fifo_count                : words currently buffered
//   underrun                  : one-cycle pulse when a fill byte was consumed
// Modports: master = producer/transmitter side, slave = feeder side.
// ---------------------------------------------------------------------------
interface spi_tx_feeder_if #(
  parameter int DEPTH = 16
) ();
  import spi_pkg::*;

  logic [SPI_WORD_W-1:0]   in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [SPI_BYTE_W-1:0]   data;
  logic                    byteSent;
  logic                    signalReceived;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    underrun;

  modport master (
    output in_data, in_valid, byteSent,
    input  in_ready, data, signalReceived, fifo_count, underrun
  );

  modport slave (
    input  in_data, in_valid, byteSent,
    output in_ready, data, signalReceived, fifo_count, underrun
  );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with combinational (show-ahead) read so the consumer can
// load dout on the same edge it pops. Pointers wrap modulo DEPTH; full/empty
// come from the occupancy counter.
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write request / data (ignored when full)
//   pop, dout  : read request (ignored when empty) / head-of-queue word
//   full, empty, count : status
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == (AW+1)'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign dout   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage has no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// ---------------------------------------------------------------------------
// spi_tx_feeder
// Buffers 16-bit measurement words and serialises them MSB-byte first onto
// the SPI slave transmitter's byte bus, advancing on its byteSent pulse.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : spi_tx_feeder_if.slave (push handshake, byte bus, status)
// Parameters: DEPTH (FIFO words, power of two >= 2), FILL (idle byte).
// ---------------------------------------------------------------------------
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int                    DEPTH = 16,
  parameter logic [SPI_BYTE_W-1:0] FILL  = SPI_FILL_BYTE
) (
  input  logic            clk,
  input  logic            rst,
  spi_tx_feeder_if.slave  bus
);

  feeder_state_t          r_state;
  feeder_state_t          w_state_next;
  logic [SPI_BYTE_W-1:0]  r_data;
  logic [SPI_BYTE_W-1:0]  r_lo_q;
  logic                   r_underrun;
  logic                   r_sig_rcv;

  logic                   w_push;
  logic                   w_pop;
  logic                   w_load_lo;
  logic                   w_load_fill;
  logic                   w_underrun_next;
  logic                   w_full;
  logic                   w_empty;
  logic [SPI_WORD_W-1:0]  w_dout;
  logic [$clog2(DEPTH):0] w_count;

  assign bus.in_ready       = !rst && !w_full;
  assign bus.data           = r_data;
  assign bus.underrun       = r_underrun;
  assign bus.signalReceived = r_sig_rcv;
  assign bus.fifo_count     = w_count;
  assign w_push             = bus.in_valid && bus.in_ready;

  sync_fifo #(
    .WIDTH (SPI_WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.in_data),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (!w_empty) w_state_next = HI;
      HI:      if (bus.byteSent) w_state_next = LO;
      LO:      if (bus.byteSent) w_state_next = w_empty ? IDLE : HI;
      default: w_state_next = IDLE;
    endcase
  end

  // Control outputs. In IDLE a pending byteSent consumed the fill byte, so
  // it flags underrun even when a word is popped on the same edge.
  always_comb begin
    w_pop           = 1'b0;
    w_load_lo       = 1'b0;
    w_load_fill     = 1'b0;
    w_underrun_next = 1'b0;
    case (r_state)
      IDLE: begin
        w_pop           = !w_empty;
        w_underrun_next = bus.byteSent;
      end
      HI:   w_load_lo = bus.byteSent;
      LO: begin
        w_pop       = bus.byteSent && !w_empty;
        w_load_fill = bus.byteSent && w_empty;
      end
      default: ;
    endcase
  end

  // Byte datapath: pops load the head word straight from the show-ahead
  // FIFO output, giving one-clock byteSent -> data latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data     <= FILL;
      r_lo_q     <= '0;
      r_underrun <= 1'b0;
      r_sig_rcv  <= 1'b0;
    end else begin
      r_underrun <= w_underrun_next;
      r_sig_rcv  <= 1'b1;
      if (w_pop) begin
        r_data <= w_dout[SPI_WORD_W-1:SPI_BYTE_W];
        r_lo_q <= w_dout[SPI_BYTE_W-1:0];
      end else if (w_load_lo) begin
        r_data <= r_lo_q;
      end else if (w_load_fill) begin
        r_data <= FILL;
      end
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// ---------------------------------------------------------------------------
// tb_spi_tx_feeder
// Drives directed and random traffic into spi_tx_feeder and compares every
// cycle against a queue-based model: a word queue for the FIFO and a byte
// queue for the word currently being presented on the byte bus.
// ---------------------------------------------------------------------------
module tb_spi_tx_feeder;

  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  spi_tx_feeder_if #(.DEPTH(DEPTH)) bus ();

  spi_tx_feeder #(.DEPTH(DEPTH), .FILL(8'hFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [15:0] m_fifo [$];
  logic [7:0]  m_held [$];
  logic        m_und = 1'b0;
  logic        m_sig = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare outputs.
  task automatic step(input logic r, input logic v, input logic [15:0] d, input logic bs);
    logic [15:0] w;
    logic        rdy;
    @(negedge clk);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.byteSent = bs;
    @(posedge clk);
    if (r) begin
      m_fifo.delete();
      m_held.delete();
      m_und = 1'b0;
      m_sig = 1'b0;
    end else begin
      rdy   = (m_fifo.size() != DEPTH);
      m_und = bs && (m_held.size() == 0);
      if (bs && m_held.size() > 0) m_held.delete(0);
      if (m_held.size() == 0 && m_fifo.size() > 0) begin
        w = m_fifo.pop_front();
        m_held.push_back(w[15:8]);
        m_held.push_back(w[7:0]);
      end
      if (v && rdy) m_fifo.push_back(d);
      m_sig = 1'b1;
    end
    #1;
    chk("data", 32'(bus.data), (m_held.size() > 0) ? 32'(m_held[0]) : 32'hFF);
    chk("fifo_count", 32'(bus.fifo_count), 32'(m_fifo.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(!r && (m_fifo.size() != DEPTH)));
    chk("underrun", 32'(bus.underrun), 32'(m_und));
    chk("signalReceived", 32'(bus.signalReceived), 32'(m_sig));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
  endtask

  // byteSent pulse followed by a realistic gap.
  task automatic send_byte();
    step(1'b0, 1'b0, 16'h0, 1'b1);
    idle(15);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.byteSent = 1'b0;

    // Reset held with activity on the inputs
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 16'h1234 + 16'(i), 1'(i % 2));
    chk("reset_data", 32'(bus.data), 32'hFF);
    idle(2);

    // Single word
    step(1'b0, 1'b1, 16'hA55A, 1'b0);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("single_hi", 32'(bus.data), 32'hA5);
    idle(3);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("single_lo", 32'(bus.data), 32'h5A);
    idle(15);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("single_fill", 32'(bus.data), 32'hFF);
    chk("single_no_underrun", 32'(bus.underrun), 32'h0);
    idle(15);

    // Underrun on an empty feeder
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("underrun_pulse", 32'(bus.underrun), 32'h1);
    step(1'b0, 1'b0, 16'h0, 1'b0);
    chk("underrun_one_cycle", 32'(bus.underrun), 32'h0);
    idle(15);

    // Fill to full (one word ends up held), then keep offering words
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 16'h0100 + 16'(i), 1'b0);
    chk("full_count", 32'(bus.fifo_count), 32'(DEPTH));
    chk("full_ready", 32'(bus.in_ready), 32'h0);
    for (int i = 0; i < 36; i++) send_byte();
    chk("drained_data", 32'(bus.data), 32'hFF);

    // Simultaneous push and pop at count 5
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 16'hC000 + 16'(i), 1'b0);
    chk("simul_pre", 32'(bus.fifo_count), 32'h5);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    idle(15);
    step(1'b0, 1'b1, 16'hC0DE, 1'b1);
    chk("simul_count", 32'(bus.fifo_count), 32'h5);
    for (int i = 0; i < 12; i++) send_byte();

    // Reset while the low byte is held
    step(1'b0, 1'b1, 16'hBEEF, 1'b0);
    idle(3);
    step(1'b0, 1'b0, 16'h0, 1'b1);
    chk("mid_lo", 32'(bus.data), 32'hEF);
    step(1'b1, 1'b0, 16'h0, 1'b0);
    chk("mid_reset_data", 32'(bus.data), 32'hFF);
    idle(2);
    send_byte();
    chk("mid_after", 32'(bus.data), 32'hFF);

    // Random traffic, including back-to-back byteSent and rare resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 2) != 0),
           16'($urandom),
           ($urandom_range(0, 5) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
